bf16_sum_accum: RTL and testbench

Sequential accumulator for probabilistic-circuit sum nodes. It accepts a stream of bf16 child terms over a valid/ready handshake and folds them into a running sum, one term per cycle, using the shared combinational bf16 adder. The accumulator drives the adder's operand ports and registers the adder's result. On the last term, or when the term limit is reached, it presents the final bf16 sum downstream and holds it until accepted.

---
 rtl/bf16_sum_accum.sv | 107 ++++++++++
 tb/tb_bf16_sum_accum.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_sum_accum.sv
// Sum-node accumulator: folds a stream of bf16 terms through an external adder
// and presents the closed sum downstream until it is accepted.
module bf16_sum_accum #(
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  output logic [15:0]      add_a,
  output logic             add_a_vld,
  output logic [15:0]      add_b,
  output logic             add_b_vld,
  input  logic [15:0]      add_z,
  input  logic             add_z_vld,
  output logic [15:0]      out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] out_cnt,
  output logic             term_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       acc, acc_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  cnt_inc;
  logic [15:0]       out_data_nx;
  logic [CNT_W-1:0]  out_cnt_nx;
  logic              term_err_nx;
  logic              accept;
  logic              fold;
  logic              close;

  assign in_rdy    = (state != DONE);
  assign accept    = in_vld & in_rdy;
  assign add_a     = acc;
  assign add_b     = in_data;
  assign add_a_vld = accept;
  assign add_b_vld = accept;
  assign out_vld   = (state == DONE);

  // a term without a valid adder result is dropped
  assign fold    = accept & add_z_vld;
  assign cnt_inc = cnt + 1'b1;
  assign close   = fold & (in_last | (cnt_inc == CNT_W'(MAX_TERMS)));

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    out_data_nx = out_data;
    out_cnt_nx  = out_cnt;
    term_err_nx = term_err;
    unique case (state)
      IDLE, ACCUM: begin
        if (fold) begin
          acc_nx   = add_z;
          cnt_nx   = cnt_inc;
          state_nx = ACCUM;
          if (close) begin
            state_nx    = DONE;
            out_data_nx = add_z;
            out_cnt_nx  = cnt_inc;
            term_err_nx = ~in_last;
          end
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_nx    = IDLE;
          acc_nx      = '0;
          cnt_nx      = '0;
          term_err_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_cnt  <= '0;
      term_err <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      out_data <= out_data_nx;
      out_cnt  <= out_cnt_nx;
      term_err <= term_err_nx;
    end
  end

endmodule

// File: tb/tb_bf16_sum_accum.sv
// Bench for bf16_sum_accum: behavioural bf16 adder, directed cases and a
// randomized stream checked against a real-valued scoreboard.
module tb_bf16_sum_accum;

  localparam int MT    = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_vld = 1'b0;
  logic             in_last = 1'b0;
  logic             in_rdy;
  logic [15:0]      add_a;
  logic             add_a_vld;
  logic [15:0]      add_b;
  logic             add_b_vld;
  logic [15:0]      add_z;
  logic             add_z_vld = 1'b1;
  logic [15:0]      out_data;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [CNT_W-1:0] out_cnt;
  logic             term_err;

  int n_chk = 0;
  int n_pass = 0;
  bit rnd_mode = 1'b0;

  bf16_sum_accum #(.MAX_TERMS(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy),
    .add_a(add_a), .add_a_vld(add_a_vld),
    .add_b(add_b), .add_b_vld(add_b_vld),
    .add_z(add_z), .add_z_vld(add_z_vld),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_cnt(out_cnt), .term_err(term_err)
  );

  always #5 clk = ~clk;

  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] b;
    if (x[14:7] == 8'd0) return 0.0;
    b = {x[15], 11'(int'(x[14:7]) + 896), x[6:0], 45'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] b;
    if (r == 0.0) return 16'h0000;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 896), b[51:45]};
  endfunction

  // external adder: values used here are exact in bf16
  always_comb add_z = r2bf(bf2r(add_a) + bf2r(add_b));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [15:0] d;
    int          c;
    bit          e;
  } exp_t;

  exp_t exp_q[$];
  real  m_sum = 0.0;
  int   m_cnt = 0;
  bit   m_done = 1'b0;

  // scoreboard: observe at negedge what the next rising edge will commit
  always @(negedge clk) begin
    if (!rst_n) begin
      m_sum = 0.0;
      m_cnt = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      chk("in_rdy", 32'(in_rdy), 32'(!m_done));
      chk("out_vld", 32'(out_vld), 32'(m_done));
      chk("add_a", 32'(add_a), 32'(r2bf(m_sum)));
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", 32'(out_data), 32'(exp_q[0].d));
          chk("sb_cnt", 32'(out_cnt), 32'(exp_q[0].c));
          chk("sb_err", 32'(term_err), 32'(exp_q[0].e));
          void'(exp_q.pop_front());
        end
        m_sum = 0.0;
        m_cnt = 0;
        m_done = 1'b0;
      end else if (in_vld && !m_done && add_z_vld) begin
        m_sum += bf2r(in_data);
        m_cnt++;
        if (in_last || m_cnt == MT) begin
          exp_q.push_back('{r2bf(m_sum), m_cnt, !in_last});
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    bit ok;
    int guard = 0;
    in_vld = 1'b1;
    in_data = d;
    in_last = last;
    do begin
      ok = in_rdy;
      step();
      guard++;
    end while (!ok && guard < 64);
    if (!ok) chk("send_timeout", 32'(guard), 32'd0);
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask

  initial begin
    int nterm;
    int k;
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_term_err", 32'(term_err), 32'd0);

    // three-term sum
    out_rdy = 1'b1;
    send(16'h3F80, 1'b0);
    send(16'h3F00, 1'b0);
    send(16'h3E80, 1'b1);
    chk("t1_vld", 32'(out_vld), 32'd1);
    chk("t1_data", 32'(out_data), 32'h3FE0);
    chk("t1_cnt", 32'(out_cnt), 32'd3);
    chk("t1_err", 32'(term_err), 32'd0);
    step();
    chk("t1_vld_clr", 32'(out_vld), 32'd0);

    // single term
    send(16'h3FC0, 1'b1);
    chk("t2_data", 32'(out_data), 32'h3FC0);
    chk("t2_cnt", 32'(out_cnt), 32'd1);
    step();

    // backpressure in DONE
    out_rdy = 1'b0;
    send(16'h3F80, 1'b1);
    in_vld = 1'b1;
    in_data = 16'h3F00;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rdy", 32'(in_rdy), 32'd0);
      chk("t3_data", 32'(out_data), 32'h3F80);
      chk("t3_cnt", 32'(out_cnt), 32'd1);
      step();
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("t3_idle_rdy", 32'(in_rdy), 32'd1);
    step();
    in_vld = 1'b0;
    in_last = 1'b0;
    chk("t3_new_data", 32'(out_data), 32'h3F00);
    chk("t3_new_cnt", 32'(out_cnt), 32'd1);
    out_rdy = 1'b1;
    step();

    // forced close at MT
    out_rdy = 1'b0;
    repeat (MT) send(16'h3E80, 1'b0);
    chk("t4_data", 32'(out_data), 32'h3F80);
    chk("t4_cnt", 32'(out_cnt), 32'(MT));
    chk("t4_err", 32'(term_err), 32'd1);
    in_vld = 1'b1;
    in_data = 16'h3E80;
    in_last = 1'b1;
    step();
    step();
    chk("t4_hold_rdy", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    step();
    step();
    in_vld = 1'b0;
    in_last = 1'b0;
    chk("t4_next_data", 32'(out_data), 32'h3E80);
    chk("t4_next_cnt", 32'(out_cnt), 32'd1);
    chk("t4_next_err", 32'(term_err), 32'd0);
    step();

    // reset mid-sum
    send(16'h3F80, 1'b0);
    send(16'h3F00, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_acc", 32'(add_a), 32'd0);
    chk("t5_vld", 32'(out_vld), 32'd0);
    send(16'h3F00, 1'b1);
    chk("t5_data", 32'(out_data), 32'h3F00);
    chk("t5_cnt", 32'(out_cnt), 32'd1);
    step();

    // dropped term
    send(16'h3F80, 1'b0);
    add_z_vld = 1'b0;
    send(16'h3F00, 1'b0);
    add_z_vld = 1'b1;
    send(16'h3E80, 1'b1);
    chk("t6_data", 32'(out_data), 32'h3FA0);
    chk("t6_cnt", 32'(out_cnt), 32'd2);
    step();

    // randomized stream
    rnd_mode = 1'b1;
    for (int s = 0; s < 60; s++) begin
      nterm = $urandom_range(1, MT + 1);
      for (int t = 0; t < nterm; t++) begin
        repeat ($urandom_range(0, 2)) step();
        k = $urandom_range(1, 8);
        add_z_vld = ($urandom_range(0, 9) != 0);
        send(r2bf(real'(k) / 8.0), (t == nterm - 1));
        add_z_vld = 1'b1;
      end
    end
    rnd_mode = 1'b0;
    out_rdy = 1'b1;
    repeat (4) step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
